// File: rtl/fifo_rd_packer_pkg.sv
// Shared types for the FIFO read-side packer: FSM state encoding and the
// lane-count to keep-mask helper.
package fifo_rd_pkg;

    typedef enum logic {
        FILL       = 1'b0,
        FLUSH_PEND = 1'b1
    } rd_state_t;

    localparam int MAX_LANES = 32;

    // Lowest `lanes` bits set; callers cast the result down to their lane count.
    function automatic logic [MAX_LANES-1:0] keep_mask(input int lanes);
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < lanes) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read port plus packed output stream of the read-side packer.
// master = packer side, slave = FIFO/downstream side.
interface fifo_rd_packer_if #(
    parameter int DSIZE = 8,
    parameter int RATIO = 4
);
    logic                   rempty;
    logic [DSIZE-1:0]       rdata;
    logic                   rinc;
    logic                   flush;
    logic                   m_valid;
    logic [DSIZE*RATIO-1:0] m_data;
    logic [RATIO-1:0]       m_keep;
    logic                   m_ready;

    modport master (
        input  rempty, rdata, flush, m_ready,
        output rinc, m_valid, m_data, m_keep
    );

    modport slave (
        output rempty, rdata, flush, m_ready,
        input  rinc, m_valid, m_data, m_keep
    );
endinterface

// File: rtl/fifo_rd_packer_outreg.sv
// Registered output slot of the packer: loads a beat, holds it until accepted,
// and reports whether a new beat may be loaded this cycle.
module fifo_rd_outreg #(
    parameter int DSIZE = 8,
    parameter int RATIO = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [DSIZE*RATIO-1:0] load_data,
    input  logic [RATIO-1:0]       load_keep,
    input  logic                   m_ready,
    output logic                   m_valid,
    output logic [DSIZE*RATIO-1:0] m_data,
    output logic [RATIO-1:0]       m_keep,
    output logic                   slot_free
);

    assign slot_free = !m_valid || m_ready;

    // Data/keep only change on load, so they stay stable while a beat waits.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_keep  <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= load_data;
            m_keep  <= load_keep;
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-domain FIFO consumer packing RATIO words per output beat, with flush.
// Optional macro FIFO_RD_CNT_EN adds the CSIZE-bit words_popped counter/port.
module fifo_rd_packer
    import fifo_rd_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int RATIO = 4
`ifdef FIFO_RD_CNT_EN
    ,
    parameter int CSIZE = 16
`endif
) (
    input  logic                   rclk,
    input  logic                   rrst,
    fifo_rd_packer_if.master       bus
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [CSIZE-1:0]       words_popped
`endif
);

    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int W  = DSIZE * RATIO;
    localparam logic [CW-1:0] LAST = CW'(RATIO - 1);

    rd_state_t        state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [W-1:0]     asm_q, merged;
    logic [CW:0]      lanes;
    logic             pop, load, slot_free;
    logic [W-1:0]     load_data;
    logic [RATIO-1:0] load_keep;

    // The last lane may only be popped when the finished beat has somewhere to go.
    assign pop      = !rrst && !bus.rempty && (state == FILL) && ((cnt != LAST) || slot_free);
    assign bus.rinc = pop;
    assign lanes    = {1'b0, cnt} + {{CW{1'b0}}, pop};

    // Assembly lanes including this cycle's pop; unused lanes are zeroed on emit.
    always_comb begin
        merged = asm_q;
        if (pop) merged[int'(cnt)*DSIZE +: DSIZE] = bus.rdata;
        load_keep = RATIO'(keep_mask(int'(lanes)));
        load_data = '0;
        for (int i = 0; i < RATIO; i++) begin
            if (load_keep[i]) load_data[i*DSIZE +: DSIZE] = merged[i*DSIZE +: DSIZE];
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        load       = 1'b0;
        case (state)
            FILL: begin
                if (pop) cnt_next = cnt + 1'b1;
                if (pop && (cnt == LAST)) begin
                    load     = 1'b1;
                    cnt_next = '0;
                end else if (bus.flush && (lanes != '0)) begin
                    if (slot_free) begin
                        load     = 1'b1;
                        cnt_next = '0;
                    end else begin
                        state_next = FLUSH_PEND;
                    end
                end
            end
            FLUSH_PEND: begin
                if (slot_free) begin
                    load       = 1'b1;
                    cnt_next   = '0;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state <= FILL;
            cnt   <= '0;
            asm_q <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            asm_q <= merged;
        end
    end

    fifo_rd_outreg #(
        .DSIZE(DSIZE),
        .RATIO(RATIO)
    ) u_outreg (
        .clk       (rclk),
        .rst       (rrst),
        .load      (load),
        .load_data (load_data),
        .load_keep (load_keep),
        .m_ready   (bus.m_ready),
        .m_valid   (bus.m_valid),
        .m_data    (bus.m_data),
        .m_keep    (bus.m_keep),
        .slot_free (slot_free)
    );

`ifdef FIFO_RD_CNT_EN
    always_ff @(posedge rclk) begin
        if (rrst) begin
            words_popped <= '0;
        end else if (pop) begin
            words_popped <= words_popped + 1'b1;
        end
    end
`endif

endmodule
